// File: rtl/led_ctrl_if.sv
// led_ctrl_if: CPU bus and LED register signals of the LED sequencer.
// master = bus bridge / LED register side, slave = led_ctrl.
interface led_ctrl_if;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_din;
    logic [31:0] bus_dout;
    logic        led_we;
    logic [31:0] led_din;
    logic [31:0] led_q;

    modport master (
        output bus_we, bus_addr, bus_din, led_q,
        input  bus_dout, led_we, led_din
    );

    modport slave (
        input  bus_we, bus_addr, bus_din, led_q,
        output bus_dout, led_we, led_din
    );
endinterface

// File: rtl/led_ctrl.sv
// led_ctrl: arbitrates the 32-bit LED register between CPU writes and a periodic pattern engine.
// Define LED_CTRL_IRQ_EN to build the step-limit-done interrupt output irq.
module led_ctrl #(
    parameter logic [31:0] DIV_RESET = 32'd25_000_000
) (
    input  logic      clk,
    input  logic      rst,
    led_ctrl_if.slave io
`ifdef LED_CTRL_IRQ_EN
    ,
    output logic      irq
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEFER = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] shadow_r;
    logic        led_we_r;
    logic        ctrl_run_r;
    logic [1:0]  ctrl_mode_r;
    logic [7:0]  ctrl_limit_r;
    logic [31:0] period_r;
    logic [31:0] cnt_r;
    logic [7:0]  count_r;
    logic        done_r;

    logic        data_wr_s;
    logic        ctrl_wr_s;
    logic        period_wr_s;
    logic        start_s;
    logic        fire_s;
    logic        dec_s;
    logic        done_set_s;
    logic        busy_s;
    logic [7:0]  count_inc_s;
    logic [31:0] reload_s;
    logic [31:0] dout_s;

    function automatic logic [31:0] step_xform(input logic [1:0] mode, input logic [31:0] v);
        logic [31:0] r;
        case (mode)
            2'b01:   r = ~v;
            2'b10:   r = {v[30:0], v[31]};
            2'b11:   r = {v[0], v[31:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign data_wr_s   = io.bus_we && (io.bus_addr == 2'd0);
    assign ctrl_wr_s   = io.bus_we && (io.bus_addr == 2'd1);
    assign period_wr_s = io.bus_we && (io.bus_addr == 2'd2);
    // PERIOD of 0 behaves as 1, so both reload the counter with 0
    assign reload_s    = (period_r == 32'd0) ? 32'd0 : (period_r - 32'd1);
    assign count_inc_s = count_r + 8'd1;
    assign busy_s      = (state_r == ST_RUN) || (state_r == ST_DEFER);

    // Next-state and step decode; a stop request outranks a due step
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        fire_s     = 1'b0;
        dec_s      = 1'b0;
        done_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && io.bus_din[0]) begin
                    state_nx_s = ST_RUN;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ctrl_wr_s && !io.bus_din[0]) begin
                    state_nx_s = ST_IDLE;
                end else if (cnt_r != 32'd0) begin
                    dec_s = 1'b1;
                end else if (data_wr_s) begin
                    state_nx_s = ST_DEFER;
                end else begin
                    fire_s = 1'b1;
                end
            end
            ST_DEFER: begin
                if (ctrl_wr_s && !io.bus_din[0]) begin
                    state_nx_s = ST_IDLE;
                end else if (data_wr_s) begin
                    state_nx_s = ST_DEFER;
                end else begin
                    fire_s = 1'b1;
                end
            end
            ST_DONE: begin
                if (ctrl_wr_s && io.bus_din[0]) begin
                    state_nx_s = ST_RUN;
                    start_s    = 1'b1;
                end else if (ctrl_wr_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
        if (fire_s && (ctrl_limit_r != 8'd0) && (count_inc_s == ctrl_limit_r)) begin
            state_nx_s = ST_DONE;
            done_set_s = 1'b1;
        end else if (fire_s) begin
            state_nx_s = ST_RUN;
        end else begin
            done_set_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // LED write port; the shadow doubles as led_din since both hold the last issued value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_we_r <= 1'b0;
            shadow_r <= 32'hFFFF_FFFF;
        end else if (data_wr_s) begin
            led_we_r <= 1'b1;
            shadow_r <= io.bus_din;
        end else if (fire_s && (ctrl_mode_r != 2'b00)) begin
            led_we_r <= 1'b1;
            shadow_r <= step_xform(ctrl_mode_r, shadow_r);
        end else begin
            led_we_r <= 1'b0;
            shadow_r <= shadow_r;
        end
    end

    // Prescaler, step count and done flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= 32'd0;
            count_r <= 8'd0;
            done_r  <= 1'b0;
        end else if (start_s) begin
            cnt_r   <= reload_s;
            count_r <= 8'd0;
            done_r  <= 1'b0;
        end else if (fire_s) begin
            cnt_r   <= reload_s;
            count_r <= count_inc_s;
            done_r  <= done_r | done_set_s;
        end else if (dec_s) begin
            cnt_r   <= cnt_r - 32'd1;
        end else begin
            cnt_r   <= cnt_r;
        end
    end

    // CTRL and PERIOD registers; reaching the limit clears run even over a same-cycle CTRL write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_run_r   <= 1'b0;
            ctrl_mode_r  <= 2'b00;
            ctrl_limit_r <= 8'd0;
            period_r     <= DIV_RESET;
        end else if (ctrl_wr_s) begin
            ctrl_run_r   <= io.bus_din[0] && !done_set_s;
            ctrl_mode_r  <= io.bus_din[2:1];
            ctrl_limit_r <= io.bus_din[15:8];
        end else if (done_set_s) begin
            ctrl_run_r   <= 1'b0;
        end else if (period_wr_s) begin
            period_r     <= io.bus_din;
        end else begin
            ctrl_run_r   <= ctrl_run_r;
        end
    end

`ifdef LED_CTRL_IRQ_EN
    logic irq_r;

    // Done interrupt; setting outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else if (done_set_s) begin
            irq_r <= 1'b1;
        end else if (ctrl_wr_s && (io.bus_din[3] || io.bus_din[0])) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    // Register readback mux
    always_comb begin
        dout_s = 32'd0;
        case (io.bus_addr)
            2'd0:    dout_s = io.led_q;
            2'd1:    dout_s = {16'd0, ctrl_limit_r, 5'd0, ctrl_mode_r, ctrl_run_r};
            2'd2:    dout_s = period_r;
            2'd3:    dout_s = {16'd0, count_r, 6'd0, done_r, busy_s};
            default: dout_s = 32'd0;
        endcase
    end

    assign io.bus_dout = dout_s;
    assign io.led_we   = led_we_r;
    assign io.led_din  = shadow_r;
endmodule
